period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, the width of the period and high-time counters.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on sig_i (minimum 2).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port en_i, input, 1 bit: measurement enable, synchronous to clk_i.
REQ-006 SHALL have port sig_i, input, 1 bit: the asynchronous square wave to be measured.
REQ-007 SHALL have port period_o, output, CNT_W bits: the last measured period, in clk_i cycles.
REQ-008 SHALL have port high_o, output, CNT_W bits: the last measured high time, in clk_i cycles.
REQ-009 SHALL have port valid_o, output, 1 bit: a one-cycle pulse when period_o and high_o update.
REQ-010 SHALL have port ovf_o, output, 1 bit: period exceeded 2^CNT_W-1 cycles; sticky.

Function
REQ-011 SHALL pass sig_i through SYNC_STAGES flops to form s_sync, register it as s_prev, and form rise = s_sync & ~s_prev.
REQ-012 SHALL implement FSM states IDLE, MEASURE and OVF.
REQ-013 IDLE: cnt=0, hcnt=0; on rise & en_i, SHALL load cnt<=1 and hcnt<=1 and go to MEASURE; no valid_o pulse.
REQ-014 MEASURE, no rise: SHALL increment cnt by 1; SHALL increment hcnt by 1 when s_sync=1.
REQ-015 MEASURE, rise: SHALL load period_o<=cnt and high_o<=hcnt, pulse valid_o, clear ovf_o, and reload cnt<=1, hcnt<=1.
REQ-016 With rises N cycles apart and s_sync high for H cycles per period, SHALL report period_o=N and high_o=H.
REQ-017 MEASURE, cnt=2^CNT_W-1 and no rise: SHALL go to OVF and set ovf_o; period_o and high_o unchanged.
REQ-018 Rise in the same cycle as cnt=2^CNT_W-1: rise has priority; SHALL perform a normal measurement of 2^CNT_W-1.
REQ-019 OVF: SHALL hold the counters without wrap; on rise, SHALL load cnt<=1, hcnt<=1 and go to MEASURE with no valid_o pulse.
REQ-020 ovf_o SHALL stay high until the next valid_o pulse or until en_i=0.
REQ-021 en_i=0 in any state: SHALL go to IDLE next cycle and clear cnt, hcnt and ovf_o; period_o and high_o retained; no valid_o pulse.
REQ-022 Latency: a sig_i rise meeting setup before clk edge k SHALL produce valid_o high after edge k+SYNC_STAGES.
REQ-023 SHALL measure correctly any sig_i with high and low phases each of at least 1 clk_i cycle (period >= 2); shorter glitches are unspecified.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst_n_i low SHALL immediately force: synchronizer flops and s_prev to 0, FSM to IDLE, cnt=hcnt=0, period_o=0, high_o=0, valid_o=0, ovf_o=0.
REQ-026 After rst_n_i deasserts, if sig_i is already high, SHALL NOT detect a rise until sig_i goes low and then high again.
REQ-027 Reset mid-measurement SHALL discard the partial count; no valid_o pulse.

Structure
REQ-028 SHALL define the state enum (IDLE, MEASURE, OVF) and the CNT_W default constant in shared package meter_pkg.
REQ-029 SHALL implement the synchronizer and edge detector as sub-module sync_edge (ports clk_i, rst_n_i, d_i, lvl_o, rise_o), parameterised by SYNC_STAGES.
REQ-030 Implementation SHALL be roughly 120-400 lines of RTL total.

Verification
REQ-031 Reset then en_i=1, sig_i square wave of period 1000 cycles, 50% duty -> first valid_o after the second rise; period_o=1000, high_o=500; subsequent pulses every 1000 cycles.
REQ-032 sig_i period 2 (1 high, 1 low) -> period_o=2, high_o=1 on every valid_o.
REQ-033 CNT_W=8, sig_i period 300 -> ovf_o=1 after 255 counted cycles, no valid_o; sig_i period switched to 100 -> first following valid_o carries period_o=100 and clears ovf_o.
REQ-034 CNT_W=8, rise with cnt exactly 255 -> valid_o, period_o=255, ovf_o=0.
REQ-035 en_i dropped mid-period, re-raised 10 cycles later -> no valid_o until two fresh rises; period_o keeps its previous value meanwhile.
REQ-036 rst_n_i pulsed low mid-period with sig_i high -> all outputs 0 asynchronously; no rise counted until sig_i goes low then high.

Source files
------------

// File: rtl/meter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | meter_pkg : shared types and constants for period_meter            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package meter_pkg;

    localparam int CNT_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        OVF     = 2'd2
    } state_e;

endpackage : meter_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_edge : multi-flop synchronizer with armed rising-edge detect  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;

    // fill_q tracks which stages hold real samples; edges are only armed
    // once a genuine low has emerged, so a line already high at reset
    // release is not mistaken for a rise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | period_meter : measures period and high time of an async signal    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module period_meter
    import meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic lvl_w;
    logic rise_w;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hcnt_q,   hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic             valid_q,  valid_d;
    logic             ovf_q,    ovf_d;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (sig_i),
        .lvl_o   (lvl_w),
        .rise_o  (rise_w)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                    if (rise_w) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                    end
                end
                MEASURE: begin
                    // A rise on the saturating cycle still counts as a full
                    // measurement, so it is tested before the overflow check.
                    if (rise_w) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        ovf_d    = 1'b0;
                        cnt_d    = CNT_ONE;
                        hcnt_d   = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = OVF;
                        ovf_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (lvl_w) begin
                            hcnt_d = hcnt_q + CNT_ONE;
                        end
                    end
                end
                OVF: begin
                    if (rise_w) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign period_o = period_q;
    assign high_o   = high_q;
    assign valid_o  = valid_q;
    assign ovf_o    = ovf_q;

endmodule : period_meter
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_period_meter : randomized scoreboard bench, 24-bit and 8-bit    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_period_meter;

    localparam int SYNC  = 2;
    localparam int NDUT  = 2;
    localparam int MAX24 = (1 << 24) - 1;
    localparam int MAX8  = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic sig   = 1'b0;

    logic [23:0] p24, h24;
    logic        v24, o24;
    logic [7:0]  p8, h8;
    logic        v8, o8;

    always #5 clk = ~clk;

    period_meter #(.CNT_W(24), .SYNC_STAGES(SYNC)) u_dut24 (
        .clk_i (clk), .rst_n_i (rst_n), .en_i (en), .sig_i (sig),
        .period_o (p24), .high_o (h24), .valid_o (v24), .ovf_o (o24)
    );

    period_meter #(.CNT_W(8), .SYNC_STAGES(SYNC)) u_dut8 (
        .clk_i (clk), .rst_n_i (rst_n), .en_i (en), .sig_i (sig),
        .period_o (p8), .high_o (h8), .valid_o (v8), .ovf_o (o8)
    );

    typedef struct {
        int cyc;
        int period;
        int high;
    } exp_t;

    exp_t q24[$];
    exp_t q8[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: sampled history of sig, plus per-DUT
    // measurement bookkeeping expressed as edge indices and sums.
    bit xs[SYNC+1];
    bit vs[SYNC+1];
    bit armed;
    bit active[NDUT];
    int start[NDUT];
    int hsum[NDUT];
    bit ovf_e[NDUT];
    int lastp[NDUT];
    int lasth[NDUT];

    function automatic int maxv(input int d);
        return (d == 0) ? MAX24 : MAX8;
    endfunction

    function automatic void push_exp(input int d, input exp_t e);
        if (d == 0) q24.push_back(e);
        else        q8.push_back(e);
    endfunction

    initial begin : p_model
        bit lv, lvalid, lpv, rise;
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i <= SYNC; i++) begin
                    xs[i] = 1'b0;
                    vs[i] = 1'b0;
                end
                armed = 1'b0;
                for (int d = 0; d < NDUT; d++) begin
                    active[d] = 1'b0;
                    start[d]  = 0;
                    hsum[d]   = 0;
                    ovf_e[d]  = 1'b0;
                    lastp[d]  = 0;
                    lasth[d]  = 0;
                end
                q24.delete();
                q8.delete();
            end else begin
                cyc++;
                lvalid = vs[SYNC-1];
                lv     = xs[SYNC-1] & lvalid;
                lpv    = xs[SYNC];
                rise   = lv & ~lpv & armed;
                if (lvalid && !lv) armed = 1'b1;
                for (int d = 0; d < NDUT; d++) begin
                    if (!en) begin
                        active[d] = 1'b0;
                        ovf_e[d]  = 1'b0;
                    end else if (rise) begin
                        if (active[d]) begin
                            e.cyc    = cyc;
                            e.period = cyc - start[d];
                            e.high   = hsum[d];
                            push_exp(d, e);
                            lastp[d] = e.period;
                            lasth[d] = e.high;
                            ovf_e[d] = 1'b0;
                        end
                        active[d] = 1'b1;
                        start[d]  = cyc;
                        hsum[d]   = 1;
                    end else if (active[d]) begin
                        if (cyc - start[d] == maxv(d)) begin
                            active[d] = 1'b0;
                            ovf_e[d]  = 1'b1;
                        end else begin
                            hsum[d] += int'(lv);
                        end
                    end
                end
                for (int i = SYNC; i > 0; i--) begin
                    xs[i] = xs[i-1];
                    vs[i] = vs[i-1];
                end
                xs[0] = sig;
                vs[0] = 1'b1;
            end
        end
    end

    task automatic check_dut(input int d, input logic v, input logic [31:0] p,
                             input logic [31:0] h, input logic o);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q24.size() > 0) : (q8.size() > 0);
        if (have) e = (d == 0) ? q24[0] : q8[0];
        if (v) begin
            checks++;
            if (!have) begin
                failures++;
                $display("FAIL unexpected_valid dut%0d cyc=%0d: got valid period=%0d high=%0d, required no valid",
                         d, cyc, p, h);
            end else begin
                if (d == 0) void'(q24.pop_front());
                else        void'(q8.pop_front());
                if (e.cyc != cyc || p !== e.period || h !== e.high) begin
                    failures++;
                    $display("FAIL measurement dut%0d: got cyc=%0d period=%0d high=%0d, required cyc=%0d period=%0d high=%0d",
                             d, cyc, p, h, e.cyc, e.period, e.high);
                end
            end
        end else if (have && e.cyc <= cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_valid dut%0d cyc=%0d: got no valid, required period=%0d high=%0d",
                     d, cyc, e.period, e.high);
            if (d == 0) void'(q24.pop_front());
            else        void'(q8.pop_front());
        end
        checks++;
        if (o !== ovf_e[d]) begin
            failures++;
            $display("FAIL ovf dut%0d cyc=%0d: got %0b, required %0b", d, cyc, o, ovf_e[d]);
        end
        checks++;
        if (p !== lastp[d] || h !== lasth[d]) begin
            failures++;
            $display("FAIL hold dut%0d cyc=%0d: got period=%0d high=%0d, required period=%0d high=%0d",
                     d, cyc, p, h, lastp[d], lasth[d]);
        end
    endtask

    initial begin : p_monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_dut(0, v24, 32'(p24), 32'(h24), o24);
                check_dut(1, v8,  32'(p8),  32'(h8),  o8);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period24"}, 32'(p24), 0);
        chk({tag, "_high24"},   32'(h24), 0);
        chk({tag, "_valid24"},  32'(v24), 0);
        chk({tag, "_ovf24"},    32'(o24), 0);
        chk({tag, "_period8"},  32'(p8),  0);
        chk({tag, "_high8"},    32'(h8),  0);
        chk({tag, "_valid8"},   32'(v8),  0);
        chk({tag, "_ovf8"},     32'(o8),  0);
    endtask

    task automatic wave(input int per, input int hi, input int n_per);
        for (int i = 0; i < n_per; i++) begin
            sig = 1'b1;
            repeat (hi) @(negedge clk);
            sig = 1'b0;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    initial begin : p_stim
        int per;
        int hi;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        rst_n = 1'b1;
        en    = 1'b1;
        repeat (5) @(negedge clk);

        wave(1000, 500, 4);
        wave(2, 1, 12);
        repeat (8) begin
            per = int'($urandom_range(2, 60));
            hi  = int'($urandom_range(1, per - 1));
            wave(per, hi, 3);
        end

        wave(300, 150, 3);
        wave(100, 40, 3);

        wave(255, 100, 3);
        wave(256, 10, 2);
        wave(255, 1, 2);

        wave(50, 25, 2);
        sig = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        sig = 1'b0;
        repeat (15) @(negedge clk);
        wave(50, 25, 3);

        repeat (6) begin
            per = int'($urandom_range(2, 40));
            hi  = int'($urandom_range(1, per - 1));
            if ($urandom_range(0, 1) == 1) en = ~en;
            wave(per, hi, 2);
        end
        en = 1'b1;
        wave(30, 12, 3);

        sig = 1'b1;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        wave(40, 10, 3);

        repeat (6) @(negedge clk);
        chk("drain_q24", q24.size(), 0);
        chk("drain_q8",  q8.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_period_meter
`default_nettype wire
